data_mem_arbiter: RTL
=====================

# data_mem_arbiter

Two-port arbiter that shares the single data-memory path between the pipeline MEM stage (CPU port) and a secondary DMA master, such as a UART loader or debug port. It sits between the MEM stage and the memory map. It issues at most one access per cycle and grants the CPU by default. A starvation counter guarantees the DMA port a slot within a bounded number of cycles. Read data returns through a registered path, one cycle after issue, to whichever port issued the read.

## Interface
Parameters:
- DATA_WIDTH, 32, data bus width
- ADDR_WIDTH, 32, address bus width
- STARVE_LIMIT, 4, max consecutive contended CPU grants before the DMA port is forced a slot; 0 gives the DMA port strict priority

Ports:
- i_clk  in  1  clock; all state updates on rising edge
- i_rst_n  in  1  reset, asynchronous, active-low
- cpu_req  in  1  CPU access request (MEM stage MemRead | MemWrite)
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_WIDTH  CPU address
- cpu_wd  in  DATA_WIDTH  CPU write data
- cpu_stall  out  1  CPU request not granted this cycle
- cpu_rvalid  out  1  pulse: cpu_rd holds data of the previous-cycle CPU read
- cpu_rd  out  DATA_WIDTH  CPU read data
- dma_req  in  1  DMA access request
- dma_we  in  1  1 = write, 0 = read
- dma_addr  in  ADDR_WIDTH  DMA address
- dma_wd  in  DATA_WIDTH  DMA write data
- dma_gnt  out  1  DMA request accepted this cycle
- dma_rvalid  out  1  pulse: dma_rd holds data of the previous-cycle DMA read
- dma_rd  out  DATA_WIDTH  DMA read data
- m_we  out  1  memory write enable
- m_re  out  1  memory read enable
- m_addr  out  ADDR_WIDTH  memory address
- m_wd  out  DATA_WIDTH  memory write data
- m_rd  in  DATA_WIDTH  memory read data, valid combinationally in the issue cycle

## Operation
- **Grant (combinational, every cycle):**
  - only cpu_req high → CPU.
  - only dma_req high → DMA.
  - both high → DMA if starve_cnt >= STARVE_LIMIT, else CPU.
  - neither high → no grant.
- **starve_cnt:**
  - Width is $clog2(STARVE_LIMIT+1), minimum 1.
  - Increments on a cycle where the CPU is granted while dma_req is high, saturating at STARVE_LIMIT.
  - Clears to 0 on a DMA grant or on any cycle with dma_req low.
- **Handshake outputs:**
  - cpu_stall = cpu_req & ~cpu_grant.
  - dma_gnt = dma_grant.
  - A port that is not granted holds req, we, addr and wd stable until granted. The arbiter does not latch requests.
- **Memory drive:**
  - The granted port's addr and wd go to m_addr and m_wd.
  - m_we = granted we.
  - m_re = granted & ~we.
  - With no grant, m_we = m_re = 0 and m_addr = m_wd = 0.
- **Read return (registered):**
  - On a granted read, capture m_rd into the issuing port's rd register and set that port's rvalid for exactly the next cycle.
  - The other port's rd register holds its value.
  - Writes produce no rvalid.
- **Simultaneous events:** a new grant in the same cycle as an rvalid pulse is legal; back-to-back reads give back-to-back rvalid pulses.
- **Reset (asynchronous assert):**
  - starve_cnt = 0; cpu_rvalid = dma_rvalid = 0; cpu_rd = dma_rd = 0.
  - A read issued in the cycle before reset produces no rvalid.
  - Combinational outputs follow the inputs during reset; the memory map gates m_we/m_re by reset externally.

## Timing
- Grant, stall, gnt and the m_* outputs: zero latency, same cycle as the request.
- Read data: one-cycle latency; rvalid and rd are registered.
- Worst-case DMA wait while the CPU requests continuously: STARVE_LIMIT cycles, DMA granted on cycle STARVE_LIMIT+1.
- Throughput: one access per cycle, no bubbles between owners.
- Reset values: cpu_rvalid = 0, dma_rvalid = 0, cpu_rd = 0, dma_rd = 0. With no requests: cpu_stall = 0, dma_gnt = 0, m_we = 0, m_re = 0, m_addr = 0, m_wd = 0.

## Test plan
- **CPU-only read:** cpu_req=1, cpu_we=0, cpu_addr=0x10010004, m_rd=0xDEADBEEF → same cycle m_re=1, cpu_stall=0; next cycle cpu_rvalid=1, cpu_rd=0xDEADBEEF; dma_rvalid stays 0.
- **Contention, STARVE_LIMIT=4, both requesting continuously:** CPU granted cycles 1-4 with dma_gnt=0; cycle 5 dma_gnt=1, cpu_stall=1, m_addr=dma_addr; cycle 6 CPU granted again with starve_cnt=0.
- **DMA write:** dma_req=1, dma_we=1, dma_addr=0x10010020, dma_wd=0x55 with no CPU request → dma_gnt=1, m_we=1, m_wd=0x55; no rvalid the next cycle.
- **Back-to-back mixed reads:** CPU read (m_rd=0x1), then forced DMA read (m_rd=0x2) → cpu_rvalid with cpu_rd=0x1, then dma_rvalid with dma_rd=0x2 on consecutive cycles; cpu_rd holds 0x1.
- **Reset mid-operation:** assert i_rst_n=0 in the cycle after a granted CPU read → cpu_rvalid=0 and cpu_rd=0 immediately; starve_cnt=0 after release.
- **STARVE_LIMIT=0:** both ports requesting → DMA granted every cycle; cpu_stall=1 until dma_req drops.

Source files
------------

// File: rtl/data_mem_arbiter.sv
// Two-port data-memory arbiter: the CPU MEM stage wins by default, and a starvation
// counter guarantees the DMA master a slot. Read data returns one cycle after issue.
module data_mem_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wd,
    output logic                  cpu_stall,
    output logic                  cpu_rvalid,
    output logic [DATA_WIDTH-1:0] cpu_rd,
    input  logic                  dma_req,
    input  logic                  dma_we,
    input  logic [ADDR_WIDTH-1:0] dma_addr,
    input  logic [DATA_WIDTH-1:0] dma_wd,
    output logic                  dma_gnt,
    output logic                  dma_rvalid,
    output logic [DATA_WIDTH-1:0] dma_rd,
    output logic                  m_we,
    output logic                  m_re,
    output logic [ADDR_WIDTH-1:0] m_addr,
    output logic [DATA_WIDTH-1:0] m_wd,
    input  logic [DATA_WIDTH-1:0] m_rd
);

    localparam int CW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic [CW-1:0] starve_cnt;
    logic          cpu_grant;
    logic          dma_grant;

    // DMA wins only when the CPU is idle or the DMA port has waited long enough.
    assign dma_grant = dma_req & (~cpu_req | (starve_cnt >= LIMIT));
    assign cpu_grant = cpu_req & ~dma_grant;

    assign cpu_stall = cpu_req & ~cpu_grant;
    assign dma_gnt   = dma_grant;

    always_comb begin
        m_we   = 1'b0;
        m_re   = 1'b0;
        m_addr = '0;
        m_wd   = '0;
        if (cpu_grant) begin
            m_we   = cpu_we;
            m_re   = ~cpu_we;
            m_addr = cpu_addr;
            m_wd   = cpu_wd;
        end else if (dma_grant) begin
            m_we   = dma_we;
            m_re   = ~dma_we;
            m_addr = dma_addr;
            m_wd   = dma_wd;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            starve_cnt <= '0;
        end else if (!dma_req || dma_grant) begin
            starve_cnt <= '0;
        end else if (cpu_grant && starve_cnt != LIMIT) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // Read data is captured only by the port that issued the read; the other holds.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cpu_rvalid <= 1'b0;
            dma_rvalid <= 1'b0;
            cpu_rd     <= '0;
            dma_rd     <= '0;
        end else begin
            cpu_rvalid <= cpu_grant & ~cpu_we;
            dma_rvalid <= dma_grant & ~dma_we;
            if (cpu_grant && !cpu_we) cpu_rd <= m_rd;
            if (dma_grant && !dma_we) dma_rd <= m_rd;
        end
    end

endmodule
